// File: rtl/acq_trigger_controller.sv
// Acquisition sequencer: pre-trigger fill, armed trigger wait,
// post-trigger fill and completion for one oscilloscope capture.
module acq_trigger_controller #(
    parameter int CNT_WIDTH = 16,
    parameter int TO_WIDTH  = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] pretrig_len,
    input  logic [CNT_WIDTH-1:0] total_len,
    input  logic                 auto_ena,
    input  logic [TO_WIDTH-1:0]  auto_timeout,
    input  logic                 src_sel,
    input  logic                 force_trig,
    input  logic                 sample_ena,
    input  logic                 trig_in,
    output logic                 trig_src,
    output logic                 det_ena,
    output logic                 buf_wr_ena,
    output logic                 busy,
    output logic                 done,
    output logic                 trig_forced,
    output logic [CNT_WIDTH-1:0] trig_position
);

    typedef enum logic [2:0] {
        IDLE,
        PRETRIG,
        ARMED,
        POSTTRIG,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0] cfg_pre;
    logic [CNT_WIDTH-1:0] cfg_total;
    logic                 cfg_auto;
    logic [TO_WIDTH-1:0]  cfg_to;
    logic                 cfg_src;

    logic [CNT_WIDTH-1:0] wr_count;
    logic [CNT_WIDTH-1:0] pre_count;
    logic [CNT_WIDTH-1:0] post_count;
    logic [CNT_WIDTH-1:0] post_len;
    logic [TO_WIDTH-1:0]  to_count;

    logic in_acq;
    logic start_ok;
    logic wr_evt;
    logic auto_hit;
    logic trig_evt;
    logic pre_hit;
    logic post_hit;

    always_comb begin
        in_acq   = (state == PRETRIG) || (state == ARMED) ||
                   (state == POSTTRIG);
        start_ok = start && !abort &&
                   ((state == IDLE) || (state == DONE));
        // an aborted clock writes nothing, including a final sample
        wr_evt   = sample_ena && in_acq && !abort;
        post_len = (cfg_total > cfg_pre) ? (cfg_total - cfg_pre)
                                         : '0;
        auto_hit = cfg_auto &&
                   ((cfg_to == '0) ||
                    (to_count == cfg_to - TO_WIDTH'(1)));
        trig_evt = (state == ARMED) &&
                   (trig_in || force_trig || auto_hit);
        pre_hit  = (pre_count == cfg_pre) ||
                   (sample_ena &&
                    (pre_count + CNT_WIDTH'(1) == cfg_pre));
        post_hit = (post_count == post_len) ||
                   (sample_ena &&
                    (post_count + CNT_WIDTH'(1) == post_len));
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) state_nxt = PRETRIG;
                end
                PRETRIG: begin
                    if (pre_hit) state_nxt = ARMED;
                end
                ARMED: begin
                    if (trig_evt)
                        state_nxt = (post_len == '0) ? DONE
                                                     : POSTTRIG;
                end
                POSTTRIG: begin
                    if (post_hit) state_nxt = DONE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cfg_pre       <= '0;
            cfg_total     <= '0;
            cfg_auto      <= 1'b0;
            cfg_to        <= '0;
            cfg_src       <= 1'b0;
            wr_count      <= '0;
            pre_count     <= '0;
            post_count    <= '0;
            to_count      <= '0;
            buf_wr_ena    <= 1'b0;
            trig_forced   <= 1'b0;
            trig_position <= '0;
        end else begin
            state      <= state_nxt;
            buf_wr_ena <= wr_evt;

            if (wr_evt)
                wr_count <= wr_count + CNT_WIDTH'(1);

            if (state == PRETRIG && sample_ena)
                pre_count <= pre_count + CNT_WIDTH'(1);

            // timeout counter restarts every time ARMED is entered
            if (state != ARMED)
                to_count <= '0;
            else
                to_count <= to_count + TO_WIDTH'(1);

            if (state != POSTTRIG)
                post_count <= '0;
            else if (sample_ena)
                post_count <= post_count + CNT_WIDTH'(1);

            if (trig_evt && !abort) begin
                trig_position <= wr_count;
                trig_forced   <= !trig_in;
            end

            if (start_ok) begin
                cfg_pre     <= pretrig_len;
                cfg_total   <= total_len;
                cfg_auto    <= auto_ena;
                cfg_to      <= auto_timeout;
                cfg_src     <= src_sel;
                wr_count    <= '0;
                pre_count   <= '0;
                trig_forced <= 1'b0;
            end
        end
    end

    assign trig_src = cfg_src;
    assign det_ena  = (state == ARMED);
    assign busy     = in_acq;
    assign done     = (state == DONE);

endmodule

// File: tb/tb_acq_trigger_controller.sv
// Bench for acq_trigger_controller: directed scenarios plus a random
// soak, compared every clock against an event-level reference model.
module tb_acq_trigger_controller;

    localparam int CW = 16;
    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, abort;
    logic [CW-1:0] pretrig_len, total_len;
    logic          auto_ena;
    logic [TW-1:0] auto_timeout;
    logic          src_sel, force_trig, sample_ena, trig_in;
    logic          trig_src, det_ena, buf_wr_ena, busy, done;
    logic          trig_forced;
    logic [CW-1:0] trig_position;

    acq_trigger_controller #(.CNT_WIDTH(CW), .TO_WIDTH(TW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .pretrig_len  (pretrig_len),
        .total_len    (total_len),
        .auto_ena     (auto_ena),
        .auto_timeout (auto_timeout),
        .src_sel      (src_sel),
        .force_trig   (force_trig),
        .sample_ena   (sample_ena),
        .trig_in      (trig_in),
        .trig_src     (trig_src),
        .det_ena      (det_ena),
        .buf_wr_ena   (buf_wr_ena),
        .busy         (busy),
        .done         (done),
        .trig_forced  (trig_forced),
        .trig_position(trig_position)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_PRE, M_ARM, M_POST, M_DONE} mphase_t;

    mphase_t m_phase;
    int m_pre, m_total, m_to, m_post_len;
    int m_wr, m_pre_seen, m_post_seen, m_armed, m_tpos;
    bit m_auto, m_src, m_forced, m_wr_pulse;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    function automatic bit chance(input int n);
        return ($urandom % n) == 0;
    endfunction

    function automatic bit m_busy();
        return m_phase inside {M_PRE, M_ARM, M_POST};
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE;
        m_pre = 0; m_total = 0; m_to = 0; m_post_len = 0;
        m_wr = 0; m_pre_seen = 0; m_post_seen = 0;
        m_armed = 0; m_tpos = 0;
        m_auto = 0; m_src = 0; m_forced = 0; m_wr_pulse = 0;
    endtask

    // one clock of the acquisition rules, using the inputs now driven
    task automatic model_clock();
        bit taken;
        int limit;
        taken = sample_ena && m_busy() && !abort;
        m_wr_pulse = taken;
        if (abort) begin
            m_phase = M_IDLE;
        end else begin
            case (m_phase)
                M_IDLE, M_DONE: if (start) begin
                    m_pre = int'(pretrig_len);
                    m_total = int'(total_len);
                    m_auto = auto_ena;
                    m_to = int'(auto_timeout);
                    m_src = src_sel;
                    m_post_len = (m_total > m_pre) ? m_total - m_pre : 0;
                    m_wr = 0;
                    m_forced = 0;
                    m_pre_seen = 0;
                    m_phase = M_PRE;
                end
                M_PRE: begin
                    if (sample_ena) m_pre_seen++;
                    if (m_pre_seen >= m_pre) begin
                        m_phase = M_ARM;
                        m_armed = 0;
                    end
                end
                M_ARM: begin
                    m_armed++;
                    limit = (m_to == 0) ? 1 : m_to;
                    if (trig_in || force_trig ||
                        (m_auto && m_armed == limit)) begin
                        m_tpos = m_wr;
                        m_forced = !trig_in;
                        m_post_seen = 0;
                        m_phase = (m_post_len == 0) ? M_DONE : M_POST;
                    end
                end
                M_POST: begin
                    if (sample_ena) m_post_seen++;
                    if (m_post_seen >= m_post_len) m_phase = M_DONE;
                end
                default: m_phase = M_IDLE;
            endcase
        end
        if (taken) m_wr = (m_wr + 1) % 65536;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy", 32'(busy), 32'(m_busy()));
        chk("det_ena", 32'(det_ena), 32'(m_phase == M_ARM));
        chk("done", 32'(done), 32'(m_phase == M_DONE));
        chk("buf_wr_ena", 32'(buf_wr_ena), 32'(m_wr_pulse));
        chk("trig_src", 32'(trig_src), 32'(m_src));
        chk("trig_forced", 32'(trig_forced), 32'(m_forced));
        chk("trig_position", 32'(trig_position), 32'(m_tpos));
        if (buf_wr_ena) pulses++;
    endtask

    task automatic step(input bit st, input bit ab, input bit se,
                        input bit ti, input bit ft);
        start = st; abort = ab; sample_ena = se;
        trig_in = ti; force_trig = ft;
        model_clock();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_cfg(input int pre, input int tot, input bit au,
                           input int to, input bit src);
        pretrig_len = CW'(pre);
        total_len = CW'(tot);
        auto_ena = au;
        auto_timeout = TW'(to);
        src_sel = src;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 0; abort = 0; sample_ena = 0;
        trig_in = 0; force_trig = 0;
        set_cfg(0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_all();
        chk("reset_pos", 32'(trig_position), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // pre 4, total 10, trig_in on the 4th armed clock
        set_cfg(4, 10, 0, 0, 0);
        pulses = 0;
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 20 && !det_ena; i++) step(0, 0, 1, 0, 0);
        chk("t1_armed", 32'(det_ena), 32'h1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 20 && !done; i++) step(0, 0, 1, 0, 0);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_pos", 32'(trig_position), 32'd7);
        chk("t1_forced", 32'(trig_forced), 32'h0);
        chk("t1_pulses", 32'(pulses), 32'd14);

        // auto trigger after 20 armed clocks
        set_cfg(3, 8, 1, 20, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 200 && !det_ena; i++)
            step(0, 0, chance(2), 0, 0);
        n = 0;
        while (det_ena && n < 40) begin
            step(0, 0, chance(2), 0, 0);
            n++;
        end
        chk("t2_auto_clocks", 32'(n), 32'd20);
        chk("t2_forced", 32'(trig_forced), 32'h1);
        for (int i = 0; i < 20 && !done; i++) step(0, 0, 1, 0, 0);
        chk("t2_done", 32'(done), 32'h1);

        // triggers during PRETRIG ignored; start in ARMED ignored
        set_cfg(8, 12, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 200 && !det_ena; i++)
            step(0, 0, chance(2), chance(2), chance(3));
        chk("t3_armed", 32'(det_ena), 32'h1);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t3_not_done", 32'(done), 32'h0);
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 20 && !done; i++) step(0, 0, 1, 0, 0);
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_src", 32'(trig_src), 32'h1);

        // abort together with the final post sample
        set_cfg(2, 6, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20 && !det_ena; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_done", 32'(done), 32'h0);
        pulses = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        chk("t4_no_wr", 32'(pulses), 32'h0);

        // post_len saturates to 0: DONE right after the trigger
        set_cfg(5, 3, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20 && !det_ena; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("t5_done", 32'(done), 32'h1);
        set_cfg(5, 3, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        chk("t5_src", 32'(trig_src), 32'h1);
        chk("t5_restart", 32'(done), 32'h0);
        step(0, 1, 0, 0, 0);

        // wr_count wraps; trig_in with force_trig is not forced
        set_cfg(16'hFFF0, 16'hFFF4, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 70000 && !det_ena; i++) step(0, 0, 1, 0, 0);
        chk("t6_armed", 32'(det_ena), 32'h1);
        for (int i = 0; i < 100; i++) step(0, 0, (i % 4) == 0, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("t6_pos", 32'(trig_position), 32'h9);
        chk("t6_forced", 32'(trig_forced), 32'h0);
        for (int i = 0; i < 100 && !done; i++)
            step(0, 0, (i % 4) == 0, 0, 0);
        chk("t6_done", 32'(done), 32'h1);

        // reset mid-acquisition
        set_cfg(2, 9, 0, 0, 1);
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        start = 0; abort = 0; sample_ena = 0;
        trig_in = 0; force_trig = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("t7_busy", 32'(busy), 32'h0);
        chk("t7_src", 32'(trig_src), 32'h0);
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // random soak
        for (int i = 0; i < 600; i++) begin
            set_cfg($urandom_range(0, 5), $urandom_range(0, 9),
                    chance(2), $urandom_range(0, 12), chance(2));
            step(chance(6), chance(25), chance(2), chance(10), chance(16));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
